// File: rtl/mode_sequencer.sv
// Mode controller: short press advances the mode, long press returns home, idle ticks auto-return home.
// Edit buttons reach only the active mode; display fields are muxed through one register stage.
module mode_sequencer #(
  parameter int N_MODES        = 3,
  parameter int SEC_W          = 6,
  parameter int MIN_W          = 6,
  parameter int HR_W           = 5,
  parameter int LONG_PRESS_CYC = 1000,
  parameter int IDLE_TICKS     = 60,
  localparam int MW            = (N_MODES > 2) ? $clog2(N_MODES) : 1
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_tick,
  input  logic                     i_mode,
  input  logic                     i_set,
  input  logic                     i_up,
  input  logic                     i_down,
  input  logic                     i_left,
  input  logic                     i_right,
  input  logic [N_MODES*SEC_W-1:0] i_sec_bus,
  input  logic [N_MODES*MIN_W-1:0] i_min_bus,
  input  logic [N_MODES*HR_W-1:0]  i_hr_bus,
  output logic [N_MODES*5-1:0]     o_btn_bus,
  output logic [MW-1:0]            o_mode,
  output logic                     o_mode_chg,
  output logic [SEC_W-1:0]         o_sec,
  output logic [MIN_W-1:0]         o_min,
  output logic [HR_W-1:0]          o_hr
);

  localparam int PW = $clog2(LONG_PRESS_CYC + 1);
  localparam int IW = (IDLE_TICKS > 0) ? $clog2(IDLE_TICKS + 1) : 1;

  localparam logic [1:0] ST_ARMED = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_PRESS = 2'd2;
  localparam logic [1:0] ST_HELD  = 2'd3;

  localparam logic [MW-1:0] LAST_MODE = MW'(N_MODES - 1);
  localparam logic [PW-1:0] LONG_LAST = PW'(LONG_PRESS_CYC - 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'((IDLE_TICKS > 0) ? IDLE_TICKS - 1 : 0);
  localparam logic [IW-1:0] IDLE_MAX  = IW'(IDLE_TICKS);

  logic [1:0]    state;
  logic [PW-1:0] press_cnt;
  logic [IW-1:0] idle_cnt;
  logic [MW-1:0] mode;
  logic          any_btn;
  logic          short_rel;
  logic          long_hit;
  logic          timeout;

  assign o_mode = mode;

  always_comb begin
    any_btn   = i_mode | i_set | i_up | i_down | i_left | i_right;
    short_rel = (state == ST_PRESS) && !i_mode;
    long_hit  = (state == ST_PRESS) && i_mode && (press_cnt == LONG_LAST);
    // A release in the same cycle takes priority over the idle timeout.
    timeout   = (IDLE_TICKS > 0) && i_tick && !any_btn && !short_rel &&
                (mode != '0) && (idle_cnt == IDLE_LAST);
  end

  always_comb begin
    o_btn_bus = '0;
    if (state == ST_IDLE) begin
      o_btn_bus[mode*5 +: 5] = {i_set, i_up, i_down, i_left, i_right};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_ARMED;
      press_cnt  <= '0;
      idle_cnt   <= '0;
      mode       <= '0;
      o_mode_chg <= 1'b0;
      o_sec      <= '0;
      o_min      <= '0;
      o_hr       <= '0;
    end else begin
      o_mode_chg <= short_rel | long_hit | timeout;
      o_sec      <= i_sec_bus[mode*SEC_W +: SEC_W];
      o_min      <= i_min_bus[mode*MIN_W +: MIN_W];
      o_hr       <= i_hr_bus[mode*HR_W +: HR_W];

      case (state)
        ST_ARMED: if (!i_mode) state <= ST_IDLE;
        ST_IDLE: begin
          press_cnt <= '0;
          if (i_mode) begin
            state     <= ST_PRESS;
            press_cnt <= PW'(1);
          end
        end
        ST_PRESS: begin
          if (!i_mode) begin
            state     <= ST_IDLE;
            press_cnt <= '0;
          end else if (long_hit) begin
            state <= ST_HELD;
          end else begin
            press_cnt <= press_cnt + 1'b1;
          end
        end
        default: begin
          press_cnt <= '0;
          if (!i_mode) state <= ST_IDLE;
        end
      endcase

      if (short_rel) begin
        mode <= (mode == LAST_MODE) ? '0 : mode + 1'b1;
      end else if (long_hit || timeout) begin
        mode <= '0;
      end

      if (IDLE_TICKS == 0 || any_btn || mode == '0 || short_rel || timeout) begin
        idle_cnt <= '0;
      end else if (i_tick && idle_cnt != IDLE_MAX) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mode_sequencer.sv
// Bench for mode_sequencer: directed scenarios plus randomized traffic against a press/tick-count model.
module tb_mode_sequencer;
  localparam int N   = 3;
  localparam int SW  = 6;
  localparam int MNW = 6;
  localparam int HW  = 5;
  localparam int LP  = 1000;
  localparam int IT  = 3;
  localparam int MW  = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst, tick, mode_b, set_b, up_b, down_b, left_b, right_b;
  logic [N*SW-1:0]  sec_bus;
  logic [N*MNW-1:0] min_bus;
  logic [N*HW-1:0]  hr_bus;
  logic [N*5-1:0]   btn_bus;
  logic [MW-1:0]    mode_o;
  logic             chg;
  logic [SW-1:0]    sec;
  logic [MNW-1:0]   min_o;
  logic [HW-1:0]    hr;

  mode_sequencer #(
    .N_MODES(N), .SEC_W(SW), .MIN_W(MNW), .HR_W(HW),
    .LONG_PRESS_CYC(LP), .IDLE_TICKS(IT)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_tick(tick), .i_mode(mode_b),
    .i_set(set_b), .i_up(up_b), .i_down(down_b), .i_left(left_b), .i_right(right_b),
    .i_sec_bus(sec_bus), .i_min_bus(min_bus), .i_hr_bus(hr_bus),
    .o_btn_bus(btn_bus), .o_mode(mode_o), .o_mode_chg(chg),
    .o_sec(sec), .o_min(min_o), .o_hr(hr)
  );

  int tests = 0;
  int fails = 0;

  // Reference: mode index, cycles the button has been held, ticks since last activity.
  int             m_mode = 0;
  int             m_held = 0;
  int             m_idle = 0;
  bit             m_armed = 1'b1;
  bit             m_long = 1'b0;
  bit             m_chg = 1'b0;
  logic [SW-1:0]  m_sec = '0;
  logic [MNW-1:0] m_min = '0;
  logic [HW-1:0]  m_hr = '0;

  task automatic cycle();
    int  old_mode;
    bit  wrote;
    bit  any;
    @(posedge clk);
    if (rst) begin
      m_mode = 0; m_held = 0; m_idle = 0; m_armed = 1'b1; m_long = 1'b0; m_chg = 1'b0;
      m_sec = '0; m_min = '0; m_hr = '0;
    end else begin
      m_sec = sec_bus[m_mode*SW +: SW];
      m_min = min_bus[m_mode*MNW +: MNW];
      m_hr  = hr_bus[m_mode*HW +: HW];
      old_mode = m_mode;
      wrote = 1'b0;
      any = mode_b | set_b | up_b | down_b | left_b | right_b;
      if (m_armed) begin
        if (!mode_b) m_armed = 1'b0;
      end else if (mode_b) begin
        m_held++;
        if (m_held == LP && !m_long) begin
          m_mode = 0; wrote = 1'b1; m_long = 1'b1;
        end
      end else begin
        if (m_held > 0 && !m_long) begin
          m_mode = (m_mode + 1) % N; wrote = 1'b1;
        end
        m_held = 0; m_long = 1'b0;
      end
      if (wrote || any || old_mode == 0) m_idle = 0;
      else if (tick) begin
        if (m_idle + 1 == IT) begin
          m_mode = 0; wrote = 1'b1; m_idle = 0;
        end else m_idle++;
      end
      m_chg = wrote;
    end
    #1;
  endtask

  task automatic press(input int len);
    mode_b = 1'b1;
    repeat (len) cycle();
    mode_b = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    int pulses = 0;
    rst = 1'b1; mode_b = 1'b1;
    repeat (3) cycle();
    tests++;
    if ({mode_o, chg, sec, min_o, hr, btn_bus} !== '0) begin
      fails++; $display("FAIL reset_state: got %h expected 0", {mode_o, chg, sec, min_o, hr, btn_bus});
    end
    rst = 1'b0;
    repeat (5) begin
      cycle();
      if (chg) pulses++;
    end
    mode_b = 1'b0;
    repeat (3) begin
      cycle();
      if (chg) pulses++;
    end
    tests++;
    if (pulses != 0 || mode_o !== 2'd0) begin
      fails++; $display("FAIL reset_held: mode %0d pulses %0d, expected mode 0 pulses 0", mode_o, pulses);
    end
  endtask

  task automatic test_short_press();
    int exp_mode;
    int prev;
    sec_bus = {6'd30, 6'd20, 6'd10};
    min_bus = {6'd33, 6'd22, 6'd11};
    hr_bus  = {5'd3, 5'd2, 5'd1};
    cycle();
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      exp_mode = (prev + 1) % 3;
      mode_b = 1'b1;
      repeat (10) cycle();
      tests++;
      if (chg !== 1'b0) begin
        fails++; $display("FAIL short_no_chg_while_held: got %b expected 0", chg);
      end
      mode_b = 1'b0;
      cycle();
      tests++;
      if (mode_o !== MW'(exp_mode) || chg !== 1'b1 || sec !== SW'(10*(prev+1))) begin
        fails++; $display("FAIL short_release: mode %0d chg %b sec %0d, expected %0d 1 %0d",
                          mode_o, chg, sec, exp_mode, 10*(prev+1));
      end
      cycle();
      tests++;
      if (chg !== 1'b0 || sec !== SW'(10*(exp_mode+1)) || hr !== HW'(exp_mode+1)) begin
        fails++; $display("FAIL short_display: chg %b sec %0d hr %0d, expected 0 %0d %0d",
                          chg, sec, hr, 10*(exp_mode+1), exp_mode+1);
      end
      prev = exp_mode;
    end
  endtask

  task automatic test_long_press();
    int pulses = 0;
    press(10); press(10);
    tests++;
    if (mode_o !== 2'd2) begin
      fails++; $display("FAIL long_setup: mode %0d expected 2", mode_o);
    end
    mode_b = 1'b1;
    repeat (LP - 1) cycle();
    tests++;
    if (mode_o !== 2'd2 || chg !== 1'b0) begin
      fails++; $display("FAIL long_early: mode %0d chg %b expected 2 0", mode_o, chg);
    end
    cycle();
    tests++;
    if (mode_o !== 2'd0 || chg !== 1'b1) begin
      fails++; $display("FAIL long_fire: mode %0d chg %b expected 0 1", mode_o, chg);
    end
    repeat (50) begin
      cycle();
      if (chg) pulses++;
    end
    mode_b = 1'b0;
    repeat (3) begin
      cycle();
      if (chg) pulses++;
    end
    tests++;
    if (pulses != 0 || mode_o !== 2'd0) begin
      fails++; $display("FAIL long_release: mode %0d pulses %0d expected 0 0", mode_o, pulses);
    end
  endtask

  task automatic test_routing();
    press(10);
    up_b = 1'b1;
    #1;
    tests++;
    if (btn_bus !== 15'b00000_01000_00000) begin
      fails++; $display("FAIL route_mode1_up: got %b expected 000000100000000", btn_bus);
    end
    mode_b = 1'b1;
    cycle();
    tests++;
    if (btn_bus !== 15'd0) begin
      fails++; $display("FAIL route_blocked: got %b expected 0", btn_bus);
    end
    mode_b = 1'b0; up_b = 1'b0;
    cycle();
    set_b = 1'b1;
    #1;
    tests++;
    if (mode_o !== 2'd2 || btn_bus !== 15'b10000_00000_00000) begin
      fails++; $display("FAIL route_mode2_set: mode %0d bus %b expected 2 100000000000000", mode_o, btn_bus);
    end
    set_b = 1'b0;
    cycle();
  endtask

  task automatic pulse_tick();
    tick = 1'b1; cycle(); tick = 1'b0; cycle(); cycle();
  endtask

  task automatic test_idle();
    rst = 1'b1; cycle(); rst = 1'b0; cycle();
    press(10);
    pulse_tick(); pulse_tick();
    tests++;
    if (mode_o !== 2'd1) begin
      fails++; $display("FAIL idle_two_ticks: mode %0d expected 1", mode_o);
    end
    tick = 1'b1; cycle(); tick = 1'b0;
    tests++;
    if (mode_o !== 2'd0 || chg !== 1'b1) begin
      fails++; $display("FAIL idle_return: mode %0d chg %b expected 0 1", mode_o, chg);
    end
    press(10);
    pulse_tick(); pulse_tick();
    left_b = 1'b1; cycle(); left_b = 1'b0;
    pulse_tick();
    tests++;
    if (mode_o !== 2'd1 || chg !== 1'b0) begin
      fails++; $display("FAIL idle_activity: mode %0d chg %b expected 1 0", mode_o, chg);
    end
    pulse_tick();
    tests++;
    if (mode_o !== 2'd1) begin
      fails++; $display("FAIL idle_restart: mode %0d expected 1", mode_o);
    end
    tick = 1'b1; cycle(); tick = 1'b0;
    tests++;
    if (mode_o !== 2'd0 || chg !== 1'b1) begin
      fails++; $display("FAIL idle_return2: mode %0d chg %b expected 0 1", mode_o, chg);
    end
  endtask

  task automatic test_reset_mid_press();
    int pulses = 0;
    press(10);
    cycle();
    mode_b = 1'b1;
    repeat (500) cycle();
    rst = 1'b1;
    cycle();
    tests++;
    if ({mode_o, chg, sec, min_o, hr, btn_bus} !== '0) begin
      fails++; $display("FAIL midpress_reset: got %h expected 0", {mode_o, chg, sec, min_o, hr, btn_bus});
    end
    rst = 1'b0;
    repeat (3) begin
      cycle();
      if (chg) pulses++;
    end
    mode_b = 1'b0;
    cycle();
    if (chg) pulses++;
    tests++;
    if (pulses != 0 || mode_o !== 2'd0) begin
      fails++; $display("FAIL midpress_no_change: mode %0d pulses %0d expected 0 0", mode_o, pulses);
    end
    press(10);
    tests++;
    if (mode_o !== 2'd1 || chg !== 1'b1) begin
      fails++; $display("FAIL midpress_after: mode %0d chg %b expected 1 1", mode_o, chg);
    end
  endtask

  task automatic test_random();
    int hi_len;
    int lo_len;
    logic [N*5-1:0] exp_btn;
    for (int seg = 0; seg < 80; seg++) begin
      hi_len = ($urandom_range(0, 9) == 0) ? LP - 1 + $urandom_range(0, 3) : $urandom_range(1, 20);
      lo_len = $urandom_range(1, 25);
      for (int c = 0; c < hi_len + lo_len; c++) begin
        mode_b  = (c < hi_len);
        tick    = ($urandom_range(0, 5) == 0);
        set_b   = ($urandom_range(0, 31) == 0);
        up_b    = ($urandom_range(0, 31) == 0);
        down_b  = ($urandom_range(0, 31) == 0);
        left_b  = ($urandom_range(0, 31) == 0);
        right_b = ($urandom_range(0, 31) == 0);
        rst     = ($urandom_range(0, 599) == 0);
        if ($urandom_range(0, 3) == 0) begin
          sec_bus = N*SW'($urandom);
          min_bus = N*MNW'($urandom);
          hr_bus  = N*HW'($urandom);
        end
        cycle();
        exp_btn = '0;
        if (!m_armed && m_held == 0) exp_btn[m_mode*5 +: 5] = {set_b, up_b, down_b, left_b, right_b};
        tests++;
        if ({mode_o, chg, sec, min_o, hr, btn_bus} !==
            {MW'(m_mode), m_chg, m_sec, m_min, m_hr, exp_btn}) begin
          fails++;
          $display("FAIL random seg %0d: mode %0d chg %b sec %0d min %0d hr %0d btn %b, expected %0d %b %0d %0d %0d %b",
                   seg, mode_o, chg, sec, min_o, hr, btn_bus, m_mode, m_chg, m_sec, m_min, m_hr, exp_btn);
        end
      end
    end
    rst = 1'b0; tick = 1'b0; mode_b = 1'b0;
    {set_b, up_b, down_b, left_b, right_b} = '0;
  endtask

  initial begin
    rst = 1'b1; tick = 1'b0; mode_b = 1'b0;
    set_b = 1'b0; up_b = 1'b0; down_b = 1'b0; left_b = 1'b0; right_b = 1'b0;
    sec_bus = '0; min_bus = '0; hr_bus = '0;
    test_reset();
    test_short_press();
    test_long_press();
    test_routing();
    test_idle();
    test_reset_mid_press();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
